// File: rtl/climate_sequencer.sv
// climate_sequencer: heater/cooler sequencer with minimum run time, dead time
// between actuator changes and a debounced, latched sensor-inconsistency fault.
module climate_sequencer #(
   parameter int unsigned MIN_RUN      = 4,
   parameter int unsigned DEAD_TIME    = 2,
   parameter int unsigned FAULT_CYCLES = 3
) (
   input  logic       clk_2,
   input  logic       reset,
   input  logic       t_ge15,
   input  logic       t_ge20,
   input  logic       enable,
   input  logic       fault_clr,
   output logic       heater,
   output logic       cooler,
   output logic       fault,
   output logic [2:0] state,
   output logic [7:0] runs
);

   localparam int unsigned RUN_W  = (MIN_RUN > 1) ? $clog2(MIN_RUN) : 1;
   localparam int unsigned DEAD_W = (DEAD_TIME > 1) ? $clog2(DEAD_TIME) : 1;
   localparam int unsigned INV_W  = $clog2(FAULT_CYCLES + 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      HEAT  = 3'd1,
      COOL  = 3'd2,
      DEAD  = 3'd3,
      FAULT = 3'd4
   } state_t;

   state_t             state_q, state_nx;
   logic [RUN_W-1:0]   run_cnt, run_nx;
   logic [DEAD_W-1:0]  dead_cnt, dead_nx;
   logic [INV_W-1:0]   inv_cnt, inv_nx;
   logic [7:0]         runs_nx;
   logic               fault_hit;

   logic heat_req, cool_req, invalid;

   // threshold-switch decode; the comfort band is the remaining code
   assign heat_req = ~t_ge15 & ~t_ge20;
   assign cool_req =  t_ge15 &  t_ge20;
   assign invalid  = ~t_ge15 &  t_ge20;

   assign state = state_q;

   // state, counters and registered actuator decode
   always_ff @(posedge clk_2 or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         run_cnt  <= '0;
         dead_cnt <= '0;
         inv_cnt  <= '0;
         runs     <= '0;
         heater   <= 1'b0;
         cooler   <= 1'b0;
         fault    <= 1'b0;
      end else begin
         state_q  <= state_nx;
         run_cnt  <= run_nx;
         dead_cnt <= dead_nx;
         inv_cnt  <= inv_nx;
         runs     <= runs_nx;
         heater   <= (state_nx == HEAT);
         cooler   <= (state_nx == COOL);
         fault    <= (state_nx == FAULT);
      end
   end

   // next-state: fault detection overrides FAULT exit, which overrides normal flow
   always_comb begin
      state_nx  = state_q;
      run_nx    = run_cnt;
      dead_nx   = dead_cnt;
      inv_nx    = inv_cnt;
      runs_nx   = runs;
      fault_hit = 1'b0;

      if (state_q != FAULT) begin
         if (invalid) begin
            if (inv_cnt == INV_W'(FAULT_CYCLES - 1)) begin
               fault_hit = 1'b1;
            end else begin
               inv_nx = inv_cnt + INV_W'(1);
            end
         end else begin
            inv_nx = '0;
         end
      end

      if (fault_hit) begin
         state_nx = FAULT;
         inv_nx   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (enable && heat_req) begin
                  state_nx = HEAT;
                  run_nx   = RUN_W'(MIN_RUN - 1);
                  runs_nx  = runs + 8'd1;
               end else if (enable && cool_req) begin
                  state_nx = COOL;
                  run_nx   = RUN_W'(MIN_RUN - 1);
                  runs_nx  = runs + 8'd1;
               end
            end
            HEAT: begin
               if (run_cnt != '0) begin
                  run_nx = run_cnt - RUN_W'(1);
               end else if (!(heat_req && enable)) begin
                  state_nx = DEAD;
                  dead_nx  = DEAD_W'(DEAD_TIME - 1);
               end
            end
            COOL: begin
               if (run_cnt != '0) begin
                  run_nx = run_cnt - RUN_W'(1);
               end else if (!(cool_req && enable)) begin
                  state_nx = DEAD;
                  dead_nx  = DEAD_W'(DEAD_TIME - 1);
               end
            end
            DEAD: begin
               if (dead_cnt == '0) begin
                  state_nx = IDLE;
               end else begin
                  dead_nx = dead_cnt - DEAD_W'(1);
               end
            end
            FAULT: begin
               if (fault_clr && !invalid) begin
                  state_nx = DEAD;
                  dead_nx  = DEAD_W'(DEAD_TIME - 1);
               end
            end
            default: state_nx = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_climate_sequencer.sv
// tb_climate_sequencer: directed vector table plus hand sequences for reset and runs wrap.
module tb_climate_sequencer;

   logic       clk_2 = 1'b0;
   logic       reset = 1'b1;
   logic       t_ge15 = 1'b1, t_ge20 = 1'b0, enable = 1'b0, fault_clr = 1'b0;
   logic       heater, cooler, fault;
   logic [2:0] state;
   logic [7:0] runs;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic       t15, t20, en, clr;
      logic       eh, ec, ef;
      logic [2:0] es;
      logic [7:0] er;
   } vec_t;

   vec_t va[$];

   climate_sequencer dut (
      .clk_2(clk_2), .reset(reset), .t_ge15(t_ge15), .t_ge20(t_ge20),
      .enable(enable), .fault_clr(fault_clr), .heater(heater), .cooler(cooler),
      .fault(fault), .state(state), .runs(runs)
   );

   always #5 clk_2 = ~clk_2;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s[%0d]: got %0h want %0h", name, idx, act, exp);
      end
   endtask

   task automatic check_all(input int idx, input logic eh, input logic ec, input logic ef,
                            input logic [2:0] es, input logic [7:0] er);
      check("heater", idx, 8'(heater), 8'(eh));
      check("cooler", idx, 8'(cooler), 8'(ec));
      check("fault",  idx, 8'(fault),  8'(ef));
      check("state",  idx, 8'(state),  8'(es));
      check("runs",   idx, runs, er);
   endtask

   // inputs: 0=heat 1=cool 2=comfort 3=invalid
   function automatic vec_t mk(input int t, input logic en, input logic clr,
                               input logic [2:0] es, input logic [7:0] er);
      vec_t v;
      v.t15 = (t == 1) || (t == 2);
      v.t20 = (t == 1) || (t == 3);
      v.en  = en;
      v.clr = clr;
      v.es  = es;
      v.er  = er;
      v.eh  = (es == 3'd1);
      v.ec  = (es == 3'd2);
      v.ef  = (es == 3'd4);
      return v;
   endfunction

   task automatic drive(input int t, input logic en, input logic clr);
      t_ge15    = (t == 1) || (t == 2);
      t_ge20    = (t == 1) || (t == 3);
      enable    = en;
      fault_clr = clr;
      @(posedge clk_2);
      #1;
   endtask

   task automatic run_vectors(input int lo, input int hi);
      for (int i = lo; i < hi; i++) begin
         t_ge15    = va[i].t15;
         t_ge20    = va[i].t20;
         enable    = va[i].en;
         fault_clr = va[i].clr;
         @(posedge clk_2);
         #1;
         check_all(i, va[i].eh, va[i].ec, va[i].ef, va[i].es, va[i].er);
      end
   endtask

   localparam int H = 0, K = 1, C = 2, I = 3;

   initial begin
      int split;
      // part A: single heat run, then heat followed by held cool
      va.push_back(mk(H, 1, 0, 3'd1, 8'd1));
      va.push_back(mk(C, 1, 0, 3'd1, 8'd1));
      va.push_back(mk(C, 1, 0, 3'd1, 8'd1));
      va.push_back(mk(C, 1, 0, 3'd1, 8'd1));
      va.push_back(mk(C, 1, 0, 3'd3, 8'd1));
      va.push_back(mk(C, 1, 0, 3'd3, 8'd1));
      va.push_back(mk(C, 1, 0, 3'd0, 8'd1));
      va.push_back(mk(C, 1, 0, 3'd0, 8'd1));
      va.push_back(mk(H, 1, 0, 3'd1, 8'd2));
      va.push_back(mk(K, 1, 0, 3'd1, 8'd2));
      va.push_back(mk(K, 1, 0, 3'd1, 8'd2));
      va.push_back(mk(K, 1, 0, 3'd1, 8'd2));
      va.push_back(mk(K, 1, 0, 3'd3, 8'd2));
      va.push_back(mk(K, 1, 0, 3'd3, 8'd2));
      va.push_back(mk(K, 1, 0, 3'd0, 8'd2));
      va.push_back(mk(K, 1, 0, 3'd2, 8'd3));
      va.push_back(mk(K, 1, 0, 3'd2, 8'd3));
      split = va.size();
      // part B (after reset): sub-threshold invalids, fault during HEAT
      va.push_back(mk(C, 1, 0, 3'd0, 8'd0));
      va.push_back(mk(I, 1, 0, 3'd0, 8'd0));
      va.push_back(mk(I, 1, 0, 3'd0, 8'd0));
      va.push_back(mk(H, 1, 0, 3'd1, 8'd1));
      va.push_back(mk(I, 1, 0, 3'd1, 8'd1));
      va.push_back(mk(I, 1, 0, 3'd1, 8'd1));
      va.push_back(mk(I, 1, 0, 3'd4, 8'd1));
      // clear while invalid ignored, then valid clear
      va.push_back(mk(I, 1, 1, 3'd4, 8'd1));
      va.push_back(mk(I, 1, 0, 3'd4, 8'd1));
      va.push_back(mk(C, 1, 1, 3'd3, 8'd1));
      va.push_back(mk(C, 1, 0, 3'd3, 8'd1));
      va.push_back(mk(C, 1, 0, 3'd0, 8'd1));
      // enable gating and minimum run with enable dropped
      va.push_back(mk(H, 0, 0, 3'd0, 8'd1));
      va.push_back(mk(H, 0, 0, 3'd0, 8'd1));
      va.push_back(mk(H, 1, 0, 3'd1, 8'd2));
      va.push_back(mk(H, 0, 0, 3'd1, 8'd2));
      va.push_back(mk(H, 0, 0, 3'd1, 8'd2));
      va.push_back(mk(H, 0, 0, 3'd1, 8'd2));
      va.push_back(mk(H, 0, 0, 3'd3, 8'd2));
      va.push_back(mk(H, 0, 0, 3'd3, 8'd2));
      va.push_back(mk(H, 0, 0, 3'd0, 8'd2));
      // clr in IDLE has no effect; fault from IDLE; interrupted invalid run
      va.push_back(mk(C, 0, 1, 3'd0, 8'd2));
      va.push_back(mk(I, 0, 0, 3'd0, 8'd2));
      va.push_back(mk(I, 0, 0, 3'd0, 8'd2));
      va.push_back(mk(C, 0, 0, 3'd0, 8'd2));
      va.push_back(mk(I, 0, 0, 3'd0, 8'd2));
      va.push_back(mk(I, 0, 0, 3'd0, 8'd2));
      va.push_back(mk(I, 0, 0, 3'd4, 8'd2));
      va.push_back(mk(C, 0, 1, 3'd3, 8'd2));
      va.push_back(mk(C, 0, 0, 3'd3, 8'd2));
      va.push_back(mk(C, 0, 0, 3'd0, 8'd2));

      // reset state
      #3;
      check_all(-1, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0);
      @(negedge clk_2);
      reset = 1'b0;

      run_vectors(0, split);

      // asynchronous reset mid-COOL drops the cooler without a clock edge
      #2;
      reset = 1'b1;
      #1;
      check_all(-2, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0);
      @(negedge clk_2);
      reset = 1'b0;
      drive(C, 1, 0);
      check("idle_after_rst", 0, 8'(state), 8'd0);
      drive(C, 1, 0);
      check("idle_after_rst", 1, 8'(state), 8'd0);

      run_vectors(split, va.size());

      // runs counter wraps modulo 256
      @(negedge clk_2);
      reset = 1'b1;
      @(negedge clk_2);
      reset = 1'b0;
      for (int r = 1; r <= 256; r++) begin
         drive(H, 1, 0);
         for (int c = 0; c < 6; c++) drive(C, 1, 0);
         if (r == 255) check("runs_255", r, runs, 8'd255);
      end
      check("runs_wrap", 256, runs, 8'd0);
      check("wrap_state", 256, 8'(state), 8'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
